// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types and constants for the biquad cascade
package iir_pkg;

    localparam int NUM_TAPS    = 5;
    localparam int DEF_DATA_W  = 14;
    localparam int DEF_COEF_W  = 18;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;

    typedef enum logic [2:0] {
        TAP_B0 = 3'd0,
        TAP_B1 = 3'd1,
        TAP_B2 = 3'd2,
        TAP_A1 = 3'd3,
        TAP_A2 = 3'd4
    } tap_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAC    = 2'd1,
        ST_COMMIT = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

    function automatic int passthrough_coef(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// rtl/iir_round_sat.sv - round-half-up, shift and saturate an accumulator to a sample
module iir_round_sat #(
    parameter int ACC_W     = 40,
    parameter int DATA_W    = 14,
    parameter int COEF_FRAC = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y,
    output logic                     clip
);

    localparam int SH_W = ACC_W - COEF_FRAC;
    localparam logic [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
    localparam logic signed [SH_W-1:0] MAX_V = {{(SH_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SH_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] biased;
    logic signed [SH_W-1:0]  shifted;

    always_comb begin
        biased  = acc + $signed(HALF);
        // dropping the low bits of a two's-complement value is an arithmetic shift
        shifted = biased[ACC_W-1:COEF_FRAC];
        clip    = 1'b0;
        if (shifted > MAX_V) begin
            y    = MAX_V[DATA_W-1:0];
            clip = 1'b1;
        end else if (shifted < MIN_V) begin
            y    = MIN_V[DATA_W-1:0];
            clip = 1'b1;
        end else begin
            y = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - N_SECT direct-form-I biquads sharing one MAC
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W    = 14,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 16,
    parameter int N_SECT    = 2,
    parameter int ACC_W     = 40
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [DATA_W-1:0]         x_in,
    output logic                             out_valid,
    output logic signed [DATA_W-1:0]         y_out,
    input  logic                             coef_we,
    input  logic [$clog2(5*N_SECT)-1:0]      coef_addr,
    input  logic signed [COEF_W-1:0]         coef_data,
    input  logic                             clear_state,
    output logic                             sat_flag
);

    localparam int N_COEF = NUM_TAPS * N_SECT;
    localparam int IDX_W  = $clog2(N_COEF);
    localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [COEF_W-1:0] ONE = COEF_W'(passthrough_coef(COEF_FRAC));
    localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'(N_SECT - 1);

    state_e                    state;
    tap_e                      tap;
    logic [SECT_W-1:0]         sect;
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [ACC_W-1:0]   acc;

    logic signed [COEF_W-1:0]  coefs [N_COEF];
    logic signed [DATA_W-1:0]  x1 [N_SECT];
    logic signed [DATA_W-1:0]  x2 [N_SECT];
    logic signed [DATA_W-1:0]  y1 [N_SECT];
    logic signed [DATA_W-1:0]  y2 [N_SECT];

    logic [IDX_W-1:0]          coef_idx;
    logic signed [DATA_W-1:0]  mul_x;
    logic signed [COEF_W-1:0]  mul_c;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      is_a_tap;
    logic signed [DATA_W-1:0]  y_sat;
    logic                      clip;
    logic                      coef_ok;

    assign in_ready = rst_n && (state == ST_IDLE) && !clear_state;
    assign coef_ok  = coef_we && (state == ST_IDLE) && (int'(coef_addr) < N_COEF);

    always_comb begin
        coef_idx = IDX_W'(int'(sect) * NUM_TAPS + int'(tap));
        mul_c    = coefs[coef_idx];
        is_a_tap = (tap == TAP_A1) || (tap == TAP_A2);
        case (tap)
            TAP_B0:  mul_x = x_cur;
            TAP_B1:  mul_x = x1[sect];
            TAP_B2:  mul_x = x2[sect];
            TAP_A1:  mul_x = y1[sect];
            TAP_A2:  mul_x = y2[sect];
            default: mul_x = '0;
        endcase
        prod     = mul_x * mul_c;
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    iir_round_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_round_sat (
        .acc  (acc),
        .y    (y_sat),
        .clip (clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tap       <= TAP_B0;
            sect      <= '0;
            x_cur     <= '0;
            acc       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            for (int i = 0; i < N_COEF; i++)
                coefs[i] <= ((i % NUM_TAPS) == 0) ? ONE : '0;
            for (int s = 0; s < N_SECT; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            // a write alongside an accept lands before the first MAC cycle reads it
            if (coef_ok)
                coefs[coef_addr] <= coef_data;

            if (clear_state) begin
                state    <= ST_IDLE;
                sat_flag <= 1'b0;
                for (int s = 0; s < N_SECT; s++) begin
                    x1[s] <= '0;
                    x2[s] <= '0;
                    y1[s] <= '0;
                    y2[s] <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            x_cur <= x_in;
                            sect  <= '0;
                            tap   <= TAP_B0;
                            state <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        if (tap == TAP_B0)
                            acc <= prod_ext;
                        else if (is_a_tap)
                            acc <= acc - prod_ext;
                        else
                            acc <= acc + prod_ext;
                        if (tap == TAP_A2)
                            state <= ST_COMMIT;
                        else
                            tap <= tap_e'(tap + 3'd1);
                    end
                    ST_COMMIT: begin
                        x2[sect] <= x1[sect];
                        x1[sect] <= x_cur;
                        y2[sect] <= y1[sect];
                        y1[sect] <= y_sat;
                        x_cur    <= y_sat;
                        sat_flag <= sat_flag | clip;
                        tap      <= TAP_B0;
                        if (sect == LAST_SECT) begin
                            state <= ST_OUT;
                        end else begin
                            sect  <= sect + 1'b1;
                            state <= ST_MAC;
                        end
                    end
                    ST_OUT: begin
                        y_out     <= x_cur;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - directed-vector bench for iir_biquad_cascade
module tb_iir_biquad_cascade;
    import iir_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [13:0] x_in;
    logic              out_valid;
    logic signed [13:0] y_out;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic signed [17:0] coef_data;
    logic              clear_state;
    logic              sat_flag;

    int vectors = 0;
    int miscompares = 0;
    int rdy_low;

    iir_biquad_cascade dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x_in        (x_in),
        .out_valid   (out_valid),
        .y_out       (y_out),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .clear_state (clear_state),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_addr = 4'(addr);
        coef_data = 18'(data);
        coef_we   = 1'b1;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic set_sect(input int s, input int b0, input int b1, input int b2,
                            input int a1, input int a2);
        write_coef(s*5+0, b0);
        write_coef(s*5+1, b1);
        write_coef(s*5+2, b2);
        write_coef(s*5+3, a1);
        write_coef(s*5+4, a2);
    endtask

    task automatic pulse_clear();
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
    endtask

    task automatic run_sample(input logic signed [13:0] x, output logic signed [13:0] y,
                              output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        x_in     = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = -1;
        rdy_low  = 0;
        y        = 'x;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (!in_ready) rdy_low++;
            if (out_valid) begin
                lat = k;
                y   = y_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors += 4;
        if (y_out !== 14'sd0) begin miscompares++; $display("FAIL reset_y_out got %0d want 0", y_out); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_passthrough();
        logic signed [13:0] y;
        int lat;
        run_sample(14'sd1419, y, lat);
        vectors += 5;
        if (y !== 14'sd1419) begin miscompares++; $display("FAIL pass_y got %0d want 1419", y); end
        if (lat !== 13) begin miscompares++; $display("FAIL pass_latency got %0d want 13", lat); end
        if (rdy_low !== 12) begin miscompares++; $display("FAIL pass_ready_low got %0d want 12", rdy_low); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL pass_ready_back got %b want 1", in_ready); end
        if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL pass_sat got %b want 0", sat_flag); end
    endtask

    task automatic test_fir();
        logic signed [13:0] xs [4] = '{14'sd4096, 14'sd0, 14'sd0, 14'sd0};
        logic signed [13:0] ex [4] = '{14'sd2048, 14'sd2048, 14'sd0, 14'sd0};
        logic signed [13:0] y;
        int lat;
        set_sect(0, 32768, 32768, 0, 0, 0);
        set_sect(1, 65536, 0, 0, 0, 0);
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            run_sample(xs[i], y, lat);
            vectors++;
            if (y !== ex[i]) begin miscompares++; $display("FAIL fir[%0d] got %0d want %0d", i, y, ex[i]); end
        end
    endtask

    task automatic test_recursion();
        logic signed [13:0] ex [5] = '{14'sd4096, 14'sd2048, 14'sd1024, 14'sd512, 14'sd256};
        logic signed [13:0] y;
        int lat;
        set_sect(0, 65536, 0, 0, -32768, 0);
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 14'sd4096 : 14'sd0, y, lat);
            vectors++;
            if (y !== ex[i]) begin miscompares++; $display("FAIL iir[%0d] got %0d want %0d", i, y, ex[i]); end
        end
        vectors++;
        if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL iir_sat got %b want 0", sat_flag); end
    endtask

    task automatic test_saturation();
        logic signed [13:0] y;
        int lat;
        set_sect(0, 131071, 0, 0, 0, 0);
        pulse_clear();
        run_sample(14'sd8191, y, lat);
        vectors += 2;
        if (y !== 14'sd8191) begin miscompares++; $display("FAIL sat_pos got %0d want 8191", y); end
        if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_flag_set got %b want 1", sat_flag); end
        run_sample(-14'sd8192, y, lat);
        vectors++;
        if (y !== -14'sd8192) begin miscompares++; $display("FAIL sat_neg got %0d want -8192", y); end
        pulse_clear();
        vectors += 2;
        if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL sat_clear got %b want 0", sat_flag); end
        if (y_out !== -14'sd8192) begin miscompares++; $display("FAIL clear_keeps_y got %0d want -8192", y_out); end
    endtask

    task automatic test_rounding();
        logic signed [13:0] xs [4] = '{14'sd3, -14'sd3, 14'sd1, -14'sd1};
        logic signed [13:0] ex [4] = '{14'sd2, -14'sd1, 14'sd1, 14'sd0};
        logic signed [13:0] y;
        int lat;
        set_sect(0, 32768, 0, 0, 0, 0);
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            run_sample(xs[i], y, lat);
            vectors++;
            if (y !== ex[i]) begin miscompares++; $display("FAIL round[%0d] got %0d want %0d", i, y, ex[i]); end
        end
    endtask

    task automatic test_mid_clear();
        logic signed [13:0] y;
        int lat;
        int seen;
        set_sect(0, 65536, 0, 0, 0, 0);
        run_sample(14'sd777, y, lat);
        x_in     = 14'sd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen     = 0;
        repeat (4) begin tick(); if (out_valid) seen++; end
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
        repeat (20) begin if (out_valid) seen++; tick(); end
        vectors += 2;
        if (seen !== 0) begin miscompares++; $display("FAIL clear_abort_pulses got %0d want 0", seen); end
        if (y_out !== 14'sd777) begin miscompares++; $display("FAIL clear_abort_y got %0d want 777", y_out); end
        run_sample(14'sd321, y, lat);
        vectors += 2;
        if (y !== 14'sd321) begin miscompares++; $display("FAIL after_clear_y got %0d want 321", y); end
        if (lat !== 13) begin miscompares++; $display("FAIL after_clear_lat got %0d want 13", lat); end
    endtask

    task automatic test_coef_during_mac();
        logic signed [13:0] y;
        int lat;
        x_in     = 14'sd500;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        coef_addr = 4'd0;
        coef_data = 18'sd32768;
        coef_we   = 1'b1;
        tick();
        coef_we   = 1'b0;
        y = 'x;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) begin y = y_out; break; end
            tick();
        end
        vectors++;
        if (y !== 14'sd500) begin miscompares++; $display("FAIL mac_write_y got %0d want 500", y); end
        write_coef(12, 0);
        run_sample(14'sd600, y, lat);
        vectors++;
        if (y !== 14'sd600) begin miscompares++; $display("FAIL dropped_write_y got %0d want 600", y); end
    endtask

    task automatic test_async_reset();
        logic signed [13:0] y;
        int lat;
        set_sect(0, 32768, 0, 0, 0, 0);
        run_sample(14'sd1000, y, lat);
        vectors++;
        if (y !== 14'sd500) begin miscompares++; $display("FAIL pre_reset_y got %0d want 500", y); end
        x_in     = 14'sd1000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (y_out !== 14'sd0) begin miscompares++; $display("FAIL areset_y got %0d want 0", y_out); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL areset_ready got %b want 0", in_ready); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_sample(14'sd1000, y, lat);
        vectors++;
        if (y !== 14'sd1000) begin miscompares++; $display("FAIL areset_coef_y got %0d want 1000", y); end
    endtask

    initial begin
        in_valid    = 1'b0;
        x_in        = '0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_data   = '0;
        clear_state = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_passthrough();
        test_fir();
        test_recursion();
        test_saturation();
        test_rounding();
        test_mid_clear();
        test_coef_during_mac();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
